// File: rtl/sw_btn_led_ctrl.sv
// sw_btn_led_ctrl: switch/button to LED controller.
//   Raw sw/btn/mode pass through 2-flop synchronizers. Each sw and btn bit is
//   then debounced by a per-lane stable bit plus counter. The debounced buttons
//   produce press pulses that drive a toggle register and a btn[0] press counter.
//   A free-running blink generator and the synchronized mode select what the
//   registered led output shows.
// Ports:
//   CLK100MHZ  in   system clock, rising edge
//   ck_rst     in   async active-low reset (deassert synchronized internally)
//   sw[N]      in   raw slide switches
//   btn[N]     in   raw push buttons (bouncing)
//   mode[2]    in   raw mode select: 00 direct, 01 toggle, 10 blink, 11 count
//   led[N]     out  registered LED drive, 1 = on
module sw_btn_led_ctrl #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HALF      = 25000000
) (
  input  logic         CLK100MHZ,
  input  logic         ck_rst,
  input  logic [N-1:0] sw,
  input  logic [N-1:0] btn,
  input  logic [1:0]   mode,
  output logic [N-1:0] led
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_HALF);

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_TOGGLE = 2'b01,
    M_BLINK  = 2'b10,
    M_COUNT  = 2'b11
  } mode_t;

  // Reset: asserts immediately, releases two edges after ck_rst rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Input synchronizers. sw and btn are handled as one 2N-bit lane vector
  // so they share a single debouncer generate loop: [N-1:0] sw, [2N-1:N] btn.
  logic [2*N-1:0] in_m, in_s;
  logic [1:0]     mode_m;
  mode_t          mode_s;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      in_m   <= '0;
      in_s   <= '0;
      mode_m <= '0;
      mode_s <= M_DIRECT;
    end else begin
      in_m   <= {btn, sw};
      in_s   <= in_m;
      mode_m <= mode;
      mode_s <= mode_t'(mode_m);
    end
  end

  // Per-lane debouncer: the stable bit only flips after the synced input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
  logic [2*N-1:0]         stable;
  logic [2*N-1:0][CW-1:0] dcnt;

  for (genvar i = 0; i < 2*N; i++) begin : g_deb
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
        stable[i] <= 1'b0;
        dcnt[i]   <= '0;
      end else if (in_s[i] == stable[i]) begin
        dcnt[i]   <= '0;
      end else if (dcnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable[i] <= ~stable[i];
        dcnt[i]   <= '0;
      end else begin
        dcnt[i]   <= dcnt[i] + 1'b1;
      end
    end
  end

  logic [N-1:0] deb_sw, deb_btn;
  assign deb_sw  = stable[N-1:0];
  assign deb_btn = stable[2*N-1:N];

  // Press pulses on debounced rising edges; release is ignored.
  logic [N-1:0] btn_q, press;
  logic [N-1:0] tog, cnt;

  assign press = deb_btn & ~btn_q;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= '0;
      tog   <= '0;
      cnt   <= '0;
    end else begin
      btn_q <= deb_btn;
      tog   <= tog ^ press;
      cnt   <= cnt + N'(press[0]);
    end
  end

  // Free-running blink, unaffected by mode.
  logic [BW-1:0] bcnt;
  logic          blink;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (bcnt == BW'(BLINK_HALF - 1)) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt  <= bcnt + 1'b1;
    end
  end

  // Output register; mode is used straight from its synchronizer.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      unique case (mode_s)
        M_DIRECT: led <= deb_sw | deb_btn;
        M_TOGGLE: led <= tog ^ deb_sw;
        M_BLINK:  led <= (deb_sw | tog) & {N{blink}};
        M_COUNT:  led <= cnt;
      endcase
    end
  end

endmodule
